// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: sequential AES InvMixColumns engine.
// A 128-bit state is accepted over a valid/ready handshake, transformed one
// 32-bit column per clock through a shared column datapath, and presented
// on out_state until downstream takes it.
// Optional build macro INV_MIXCOL_PARALLEL_EN: instantiates four column
// datapaths so the whole state is transformed in a single BUSY cycle.
module inv_mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_r;
  state_t       state_nxt_s;
  logic         load_s;
  logic         step_s;
  logic [127:0] work_r;
  logic [127:0] work_step_s;
`ifndef INV_MIXCOL_PARALLEL_EN
  logic [1:0]   col_r;
  logic [31:0]  col_in_s;
  logic [31:0]  col_out_s;
`endif

  // Multiply by x in GF(2^8), reducing modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns of one column; byte 0 is the most significant byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Handshake outputs decode from the FSM state; only in_ready in DONE
  // looks at out_ready so a new state can enter as the old one leaves.
  assign out_valid = (state_r == DONE);
  assign in_ready  = (state_r == IDLE) | ((state_r == DONE) & out_ready);
  assign out_state = work_r;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode plus load/step strobes for the working register.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = BUSY;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        step_s = 1'b1;
`ifdef INV_MIXCOL_PARALLEL_EN
        state_nxt_s = DONE;
`else
        if (col_r == 2'd3) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            state_nxt_s = BUSY;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

`ifdef INV_MIXCOL_PARALLEL_EN
  // All four columns transformed at once.
  always_comb begin
    work_step_s = {inv_mix_col(work_r[127:96]), inv_mix_col(work_r[95:64]),
                   inv_mix_col(work_r[63:32]),  inv_mix_col(work_r[31:0])};
  end
`else
  // Select the column addressed by col for the shared datapath.
  always_comb begin
    case (col_r)
      2'd0:    col_in_s = work_r[127:96];
      2'd1:    col_in_s = work_r[95:64];
      2'd2:    col_in_s = work_r[63:32];
      2'd3:    col_in_s = work_r[31:0];
      default: col_in_s = 32'h0000_0000;
    endcase
  end

  assign col_out_s = inv_mix_col(col_in_s);

  // Splice the transformed column back into its slot.
  always_comb begin
    work_step_s = work_r;
    case (col_r)
      2'd0:    work_step_s[127:96] = col_out_s;
      2'd1:    work_step_s[95:64]  = col_out_s;
      2'd2:    work_step_s[63:32]  = col_out_s;
      2'd3:    work_step_s[31:0]   = col_out_s;
      default: work_step_s         = work_r;
    endcase
  end

  // Column counter: cleared on accept, advanced once per BUSY edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r <= 2'd0;
    end else if (load_s) begin
      col_r <= 2'd0;
    end else if (step_s) begin
      col_r <= col_r + 2'd1;
    end else begin
      col_r <= col_r;
    end
  end
`endif

  // Working register: captures the input on accept, then is transformed in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_r <= 128'h0;
    end else if (load_s) begin
      work_r <= in_state;
    end else if (step_s) begin
      work_r <= work_step_s;
    end else begin
      work_r <= work_r;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed testbench for inv_mix_columns_seq using hand-computed vectors.
module tb_inv_mix_columns_seq;

`ifdef INV_MIXCOL_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif

  // Known column pairs (input -> InvMixColumns output).
  localparam logic [127:0] S1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] S2 = 128'h046681e5_8e4da1bc_c6c6c6c6_00000000;
  localparam logic [127:0] E2 = 128'hd4bf5d30_db135345_c6c6c6c6_00000000;
  localparam logic [127:0] S3 = 128'h9fdc589d_01010101_046681e5_8e4da1bc;
  localparam logic [127:0] E3 = 128'hf20a225c_01010101_d4bf5d30_db135345;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int n_tests = 0;
  int n_fail  = 0;

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Send one state from IDLE, wait (bounded) for the result, check it and let it drain.
  task automatic run_one(input string tag, input logic [127:0] s, input logic [127:0] e);
    int n;
    in_state  = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    in_state = ~s;
    n = 0;
    while (!out_valid && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'(LAT));
    chk({tag, "_data"}, out_state, e);
    tick;
    chk({tag, "_drained"}, {126'h0, out_valid, in_ready}, {126'h0, 1'b0, 1'b1});
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = 128'h0;

    // Reset values, before any clock edge.
    #2;
    chk("rst_in_ready", {127'h0, in_ready}, {127'h0, 1'b1});
    chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
    chk("rst_out_state", out_state, 128'h0);
    tick;
    tick;
    rst = 1'b0;
    tick;

    // FIPS-197 columns, exact latency, input changed after accept.
    in_state  = S1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    in_state = 128'hffffffff_00000000_12345678_9abcdef0;
    chk("fips_busy_in_ready", {127'h0, in_ready}, 128'h0);
    for (int i = 1; i < LAT; i++) begin
      chk("fips_not_yet_valid", {127'h0, out_valid}, 128'h0);
      tick;
    end
    chk("fips_not_yet_valid", {127'h0, out_valid}, 128'h0);
    tick;
    chk("fips_valid", {127'h0, out_valid}, {127'h0, 1'b1});
    chk("fips_data", out_state, E1);
    tick;
    chk("fips_consumed", {126'h0, out_valid, in_ready}, {126'h0, 1'b0, 1'b1});

    // Round vector column and all-zero state.
    run_one("round", S2, E2);
    run_one("zero", 128'h0, 128'h0);

    // Back-to-back: second accepted on the edge the first is consumed.
    in_state  = S2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick;
    in_state = S3;
    for (int i = 1; i < LAT; i++) tick;
    chk("b2b_first_not_yet", {127'h0, out_valid}, 128'h0);
    tick;
    chk("b2b_first_valid", {127'h0, out_valid}, {127'h0, 1'b1});
    chk("b2b_first_data", out_state, E2);
    chk("b2b_in_ready_done", {127'h0, in_ready}, {127'h0, 1'b1});
    tick;
    in_valid = 1'b0;
    in_state = 128'h0;
    chk("b2b_second_accepted", {126'h0, out_valid, in_ready}, 128'h0);
    for (int i = 1; i < LAT; i++) tick;
    chk("b2b_second_not_yet", {127'h0, out_valid}, 128'h0);
    tick;
    chk("b2b_second_valid", {127'h0, out_valid}, {127'h0, 1'b1});
    chk("b2b_second_data", out_state, E3);
    tick;
    chk("b2b_idle", {126'h0, out_valid, in_ready}, {126'h0, 1'b0, 1'b1});

    // Backpressure: hold out_ready low in DONE for 10 cycles.
    out_ready = 1'b0;
    in_state  = S3;
    in_valid  = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < LAT; i++) tick;
    in_valid = 1'b1;
    in_state = S1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_flags", {126'h0, out_valid, in_ready}, {126'h0, 1'b1, 1'b0});
      chk("bp_hold_data", out_state, E3);
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {127'h0, in_ready}, {127'h0, 1'b1});
    tick;
    chk("bp_one_transfer", {126'h0, out_valid, in_ready}, {126'h0, 1'b0, 1'b1});
    tick;
    chk("bp_stays_idle", {126'h0, out_valid, in_ready}, {126'h0, 1'b0, 1'b1});

    // Reset in the middle of BUSY.
    in_state = S1;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    #1;
    chk("midrst_flags", {126'h0, out_valid, in_ready}, {126'h0, 1'b0, 1'b1});
    chk("midrst_out_state", out_state, 128'h0);
    #1;
    rst = 1'b0;
    tick;
    tick;
    tick;
    tick;
    chk("midrst_no_output", {127'h0, out_valid}, 128'h0);
    run_one("after_rst", S3, E3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
